// File: rtl/mem_write_buffer.sv
// Four-entry store buffer in front of the RAM controller. Buffered writes drain
// ahead of any cache fill so a granted fill always sees every earlier store.
module mem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        store_req,
    input  logic [15:0] store_addr,
    input  logic [15:0] store_data,
    output logic        store_stall,
    input  logic        i_miss,
    input  logic        d_miss,
    output logic        i_grant,
    output logic        d_grant,
    input  logic        fill_done,
    output logic        ram_write,
    output logic [15:0] ram_write_address,
    output logic [15:0] ram_write_data,
    output logic [2:0]  occupancy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [15:0] addr_mem [DEPTH];
    logic [15:0] data_mem [DEPTH];
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  count, next_count;
    logic        owner_d;
    logic        enq, deq, miss, fill_entry;

    // Outputs are forced quiet while rst is high so the reset cycle itself is clean.
    always_comb begin
        store_stall = 1'b0;
        deq         = 1'b0;
        if (!rst) begin
            store_stall = (count == 3'd4) || (state == DRAIN);
            deq         = (count != 3'd0) && ((state == IDLE) || (state == DRAIN));
        end
        ram_write         = deq;
        enq               = store_req && !store_stall;
        next_count        = count + 3'(enq) - 3'(deq);
        miss              = i_miss || d_miss;
        i_grant           = !rst && (state == FILL) && !owner_d;
        d_grant           = !rst && (state == FILL) && owner_d;
        occupancy         = rst ? 3'd0 : count;
        ram_write_address = addr_mem[rd_ptr];
        ram_write_data    = data_mem[rd_ptr];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (miss) next_state = (next_count == 3'd0) ? FILL : DRAIN;
            DRAIN: begin
                if (!miss)               next_state = IDLE;
                else if (count == 3'd0)  next_state = FILL;
            end
            FILL:  if (fill_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        fill_entry = (next_state == FILL) && (state != FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_ptr  <= 2'd0;
            wr_ptr  <= 2'd0;
            count   <= 3'd0;
            owner_d <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (enq)        wr_ptr  <= wr_ptr + 2'd1;
            if (deq)        rd_ptr  <= rd_ptr + 2'd1;
            if (fill_entry) owner_d <= d_miss;
        end
    end

    // Entry storage is never cleared; ram_write qualifies its contents.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= store_addr;
            data_mem[wr_ptr] <= store_data;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: directed table, multi-cycle corner sequences and a
// randomized run checked against a queue-based model of the buffer.
module tb_mem_write_buffer;

    logic        clk = 1'b0;
    logic        rst, store_req, i_miss, d_miss, fill_done;
    logic [15:0] store_addr, store_data;
    logic        store_stall, i_grant, d_grant, ram_write;
    logic [15:0] ram_write_address, ram_write_data;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    mem_write_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .store_req(store_req), .store_addr(store_addr),
        .store_data(store_data), .store_stall(store_stall), .i_miss(i_miss),
        .d_miss(d_miss), .i_grant(i_grant), .d_grant(d_grant), .fill_done(fill_done),
        .ram_write(ram_write), .ram_write_address(ram_write_address),
        .ram_write_data(ram_write_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, req;
        logic [15:0] addr, data;
        logic        im, dm, fd;
        logic [38:0] exp_v;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    function automatic logic [38:0] pk(input logic stall, input logic rw, input logic [15:0] a,
                                       input logic [15:0] d, input logic ig, input logic dg,
                                       input logic [2:0] occ);
        return {stall, rw, a, d, ig, dg, occ};
    endfunction

    function automatic logic [15:0] dat(input logic [15:0] a);
        return {8'hD0, a[7:0]};
    endfunction

    task automatic check(input string name, input logic [38:0] exp_v);
        logic [38:0] act, m;
        act = {store_stall, ram_write, ram_write_address, ram_write_data, i_grant, d_grant, occupancy};
        m = exp_v[37] ? '1 : {2'b11, 32'h0, 5'h1f};
        n_cmp++;
        if ((act & m) !== (exp_v & m)) begin
            n_err++;
            $display("FAIL %s: got stall=%b wr=%b a=%h d=%h ig=%b dg=%b occ=%0d, want stall=%b wr=%b a=%h d=%h ig=%b dg=%b occ=%0d",
                     name, act[38], act[37], act[36:21], act[20:5], act[4], act[3], act[2:0],
                     exp_v[38], exp_v[37], exp_v[36:21], exp_v[20:5], exp_v[4], exp_v[3], exp_v[2:0]);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check the outputs of that cycle.
    task automatic cyc(input string name, input logic r, input logic req, input logic [15:0] a,
                       input logic im, input logic dm, input logic fd, input logic [38:0] exp_v);
        @(negedge clk);
        rst = r; store_req = req; store_addr = a; store_data = dat(a);
        i_miss = im; d_miss = dm; fill_done = fd;
        #1 check(name, exp_v);
    endtask

    task automatic do_reset();
        cyc("reset", 1, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        cyc("post_reset", 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t tbl[11];

    // Reference model state
    ent_t q[$];
    int   mst;
    bit   mown_d;

    initial begin
        rst = 1; store_req = 0; store_addr = 0; store_data = 0;
        i_miss = 0; d_miss = 0; fill_done = 0;

        // Two back-to-back stores drain in order, then a dual miss hands off D then I.
        tbl[0]  = '{0, 1, 16'h0010, 16'hAAAA, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 1, 16'h0012, 16'hBBBB, 0, 0, 0, pk(0, 1, 16'h0010, 16'hAAAA, 0, 0, 1)};
        tbl[2]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, pk(0, 1, 16'h0012, 16'hBBBB, 0, 0, 1)};
        tbl[3]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 0, pk(0, 0, 0, 0, 0, 1, 0)};
        tbl[6]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 1, pk(0, 0, 0, 0, 0, 1, 0)};
        tbl[7]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 0)};
        tbl[9]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 1, pk(0, 0, 0, 0, 1, 0, 0)};
        tbl[10] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; store_req = tbl[i].req; store_addr = tbl[i].addr;
            store_data = tbl[i].data; i_miss = tbl[i].im; d_miss = tbl[i].dm;
            fill_done = tbl[i].fd;
            #1 check($sformatf("table[%0d]", i), tbl[i].exp_v);
        end

        // Five stores during a D fill: four fit, fifth stalls, nothing writes until fill_done.
        do_reset();
        cyc("fill5_miss",   0, 0, 0,       0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0));
        cyc("fill5_st0",    0, 1, 16'h0100, 0, 1, 0, pk(0, 0, 0, 0, 0, 1, 0));
        cyc("fill5_st1",    0, 1, 16'h0101, 0, 1, 0, pk(0, 0, 0, 0, 0, 1, 1));
        cyc("fill5_st2",    0, 1, 16'h0102, 0, 1, 0, pk(0, 0, 0, 0, 0, 1, 2));
        cyc("fill5_st3",    0, 1, 16'h0103, 0, 1, 0, pk(0, 0, 0, 0, 0, 1, 3));
        cyc("fill5_st4",    0, 1, 16'h0104, 0, 1, 0, pk(1, 0, 0, 0, 0, 1, 4));
        cyc("fill5_done",   0, 1, 16'h0104, 0, 0, 1, pk(1, 0, 0, 0, 0, 1, 4));
        cyc("fill5_dr0",    0, 0, 0,       0, 0, 0, pk(1, 1, 16'h0100, dat(16'h0100), 0, 0, 4));
        cyc("fill5_dr1",    0, 0, 0,       0, 0, 0, pk(0, 1, 16'h0101, dat(16'h0101), 0, 0, 3));
        cyc("fill5_dr2",    0, 0, 0,       0, 0, 0, pk(0, 1, 16'h0102, dat(16'h0102), 0, 0, 2));
        cyc("fill5_dr3",    0, 0, 0,       0, 0, 0, pk(0, 1, 16'h0103, dat(16'h0103), 0, 0, 1));
        cyc("fill5_empty",  0, 0, 0,       0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));

        // Three buffered entries then d_miss: drain through DRAIN, grant after empty.
        do_reset();
        cyc("drain_im",     0, 0, 0,       1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        cyc("drain_st0",    0, 1, 16'h0200, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 0));
        cyc("drain_st1",    0, 1, 16'h0201, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 1));
        cyc("drain_st2",    0, 1, 16'h0202, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 2));
        cyc("drain_fd",     0, 0, 0,       0, 0, 1, pk(0, 0, 0, 0, 1, 0, 3));
        cyc("drain_w0",     0, 0, 0,       0, 1, 0, pk(0, 1, 16'h0200, dat(16'h0200), 0, 0, 3));
        cyc("drain_w1",     0, 1, 16'h0999, 0, 1, 0, pk(1, 1, 16'h0201, dat(16'h0201), 0, 0, 2));
        cyc("drain_w2",     0, 0, 0,       0, 1, 0, pk(1, 1, 16'h0202, dat(16'h0202), 0, 0, 1));
        cyc("drain_zero",   0, 0, 0,       0, 1, 0, pk(1, 0, 0, 0, 0, 0, 0));
        cyc("drain_dgrant", 0, 0, 0,       0, 1, 0, pk(0, 0, 0, 0, 0, 1, 0));
        cyc("drain_fd2",    0, 0, 0,       0, 0, 1, pk(0, 0, 0, 0, 0, 1, 0));
        cyc("drain_idle",   0, 0, 0,       0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));

        // Reset in the middle of a fill discards the buffered stores.
        do_reset();
        cyc("rstfill_im",   0, 0, 0,       1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        cyc("rstfill_st0",  0, 1, 16'h0300, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 0));
        cyc("rstfill_st1",  0, 1, 16'h0301, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 1));
        cyc("rstfill_st2",  0, 1, 16'h0302, 1, 0, 0, pk(0, 0, 0, 0, 1, 0, 2));
        cyc("rstfill_rst",  1, 1, 16'h0303, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        cyc("rstfill_aft0", 0, 0, 0,       0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        cyc("rstfill_aft1", 0, 0, 0,       0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));

        // Randomized run against the queue model; addresses are unique so order is checked.
        begin
            logic        r, req, im, dm, fd;
            logic        x_stall, x_rw, x_ig, x_dg, acc;
            logic [15:0] a_next, x_a, x_d, d_r;
            int          sz0;
            bit          miss;
            do_reset();
            q.delete(); mst = 0; mown_d = 0;
            a_next = 16'h1000; im = 0; dm = 0;
            for (int c = 0; c < 3000; c++) begin
                r   = ($urandom_range(199) == 0);
                req = ($urandom_range(3) != 0);
                d_r = 16'($urandom);
                if (!im && $urandom_range(15) == 0) im = 1;
                if (!dm && $urandom_range(15) == 0) dm = 1;
                if ($urandom_range(63) == 0) im = 0;
                if ($urandom_range(63) == 0) dm = 0;
                fd = (mst == 2) && ($urandom_range(3) == 0);

                x_stall = !r && (q.size() == 4 || mst == 1);
                x_rw    = !r && q.size() != 0 && mst != 2;
                x_a     = x_rw ? q[0].a : 16'h0;
                x_d     = x_rw ? q[0].d : 16'h0;
                x_ig    = !r && mst == 2 && !mown_d;
                x_dg    = !r && mst == 2 && mown_d;

                @(negedge clk);
                rst = r; store_req = req; store_addr = a_next; store_data = d_r;
                i_miss = im; d_miss = dm; fill_done = fd;
                #1 check($sformatf("rand[%0d]", c),
                         pk(x_stall, x_rw, x_a, x_d, x_ig, x_dg, r ? 3'd0 : 3'(q.size())));
                @(posedge clk);

                if (r) begin
                    q.delete(); mst = 0; mown_d = 0;
                end else begin
                    acc  = req && !x_stall;
                    sz0  = q.size();
                    miss = im || dm;
                    if (x_rw) void'(q.pop_front());
                    if (acc) begin
                        q.push_back('{a: a_next, d: d_r});
                        a_next++;
                    end
                    if (mst == 0) begin
                        if (miss) begin
                            if (q.size() == 0) begin mst = 2; mown_d = dm; end
                            else mst = 1;
                        end
                    end else if (mst == 1) begin
                        if (!miss) mst = 0;
                        else if (sz0 == 0) begin mst = 2; mown_d = dm; end
                    end else if (fd) begin
                        mst = 0;
                        if (mown_d) dm = 0; else im = 0;
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
